// File: rtl/efuse_apb_reader_if.sv
// APB3 slave-side bundle for the eFuse reader.
// Master drives the request; slave returns data, ready and error.
interface efuse_apb_reader_if #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/efuse_apb_reader.sv
// Read-only APB view of an eFuse array, fetched bit-serially per byte.
// Optional one-entry byte cache: define EFUSE_APB_READER_CACHE_EN.
module efuse_apb_reader #(
    parameter int EFUSE_BIT      = 1024,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int STRB_CYC       = 10,
    localparam int EAW           = $clog2(EFUSE_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    efuse_apb_reader_if.slave apb,
    output logic             efuse_csb_o,
    output logic             efuse_strobe_o,
    output logic [EAW-1:0]   efuse_addr_o,
    input  logic             efuse_dout_i
);
    localparam int NB = EFUSE_BIT / 8;
    localparam int BW = EAW - 3;
    localparam logic [3:0] CNT_LAST = 4'(STRB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STRB,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BW-1:0]             a_q, a_d;
    logic [2:0]                bit_q, bit_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [7:0]                byte_q, byte_d;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic          acc;
    logic          in_range;
    logic [BW-1:0] idx;
    logic          hit;
    logic [7:0]    hit_data;
    logic          fill;
    logic          ready;
    logic          slverr;
    logic          unused_pwdata;

    assign unused_pwdata = ^apb.pwdata;

    // Reset gates the access decode so pready reads 1 while rst is held
    assign acc      = apb.psel & apb.penable & ~rst;
    assign in_range = 32'(apb.paddr) < 32'(NB);
    assign idx      = BW'(apb.paddr);

`ifdef EFUSE_APB_READER_CACHE_EN
    logic          cvalid_q;
    logic [BW-1:0] ctag_q;
    logic [7:0]    cdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cvalid_q <= 1'b0;
            ctag_q   <= '0;
            cdata_q  <= '0;
        end else if (fill) begin
            cvalid_q <= 1'b1;
            ctag_q   <= a_q;
            cdata_q  <= byte_q;
        end
    end

    assign hit      = cvalid_q && (ctag_q == idx);
    assign hit_data = cdata_q;
`else
    assign hit      = 1'b0;
    assign hit_data = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            byte_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            prdata_q <= prdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        prdata_d = prdata_q;
        ready    = 1'b1;
        slverr   = 1'b0;
        fill     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (apb.pwrite) begin
                        slverr = 1'b1;
                    end else if (!in_range) begin
                        slverr   = 1'b1;
                        prdata_d = '0;
                    end else if (hit) begin
                        prdata_d = APB_DATA_WIDTH'(hit_data);
                    end else begin
                        ready   = 1'b0;
                        a_d     = idx;
                        bit_d   = '0;
                        cnt_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                ready   = 1'b0;
                cnt_d   = '0;
                state_d = STRB;
            end
            STRB: begin
                ready = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    byte_d[bit_q] = efuse_dout_i;
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                prdata_d = APB_DATA_WIDTH'(byte_q);
                fill     = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // Response fields are combinational so zero-wait replies land in the first access cycle
    assign apb.prdata  = prdata_d;
    assign apb.pready  = ready;
    assign apb.pslverr = slverr;

    assign efuse_csb_o    = !((state_q == SETUP) || (state_q == STRB));
    assign efuse_strobe_o = (state_q == STRB);
    assign efuse_addr_o   = {a_q, bit_q};
endmodule
